goldschmidt_ctrl: RTL and testbench

//  Control FSM that drives the Goldschmidt divider datapath's control inputs.

---
 rtl/gs_ctrl_pkg.sv | 19 +
 rtl/gs_iter_counter.sv | 36 +++
 rtl/goldschmidt_ctrl.sv | 112 +++++++++++
 tb/tb_goldschmidt_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gs_ctrl_pkg.sv
// Shared types for the Goldschmidt divider control FSM: state encoding and
// multiplier operand-select codes driven onto sel_ND_mux.
package gs_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    REF_D  = 3'd3,
    REF_N  = 3'd4,
    DONE   = 3'd5
  } gs_state_t;

  localparam logic [1:0] SEL_IA_D = 2'b00;
  localparam logic [1:0] SEL_IA_N = 2'b01;
  localparam logic [1:0] SEL_K_D  = 2'b10;
  localparam logic [1:0] SEL_K_N  = 2'b11;

endpackage

// File: rtl/gs_iter_counter.sv
// Refinement-pair counter: latches the requested iteration count on clear,
// counts completed K*N steps and flags when the current pair is the last one.
module gs_iter_counter #(
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [IW-1:0] iter_in,
  output logic          iter_zero,
  output logic          last_iter
);

  logic [IW-1:0] cnt_reg;
  logic [IW-1:0] iter_reg;
  logic [IW:0]   cnt_plus_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      iter_reg <= '0;
    end else if (clear) begin
      cnt_reg  <= '0;
      iter_reg <= iter_in;
    end else if (inc) begin
      cnt_reg  <= cnt_reg + IW'(1);
    end
  end

  // One extra bit so cnt+1 cannot wrap when iter_reg sits at the top of its range.
  assign cnt_plus_one = {1'b0, cnt_reg} + (IW+1)'(1);
  assign last_iter    = cnt_plus_one >= {1'b0, iter_reg};
  assign iter_zero    = (iter_reg == '0);

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Control FSM for the Goldschmidt divider: IA*D, IA*N, then num_iter K*D/K*N pairs.
// Define GS_CTRL_ABORT_EN to add the abort input that cancels a running division.
module goldschmidt_ctrl
  import gs_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 15,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] num_iter,
`ifdef GS_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          load_regN,
  output logic          load_regD,
  output logic [1:0]    sel_ND_mux,
  output logic          sel_K_mux
);

  gs_state_t     state_reg;
  gs_state_t     state_next;
  logic          accept;
  logic          iter_zero;
  logic          last_iter;
  logic [IW-1:0] iter_clamped;

  assign accept       = (state_reg == IDLE) && start;
  assign iter_clamped = (num_iter > IW'(MAX_ITER)) ? IW'(MAX_ITER) : num_iter;

  gs_iter_counter #(
    .IW (IW)
  ) u_iter_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .inc       (state_reg == REF_N),
    .iter_in   (iter_clamped),
    .iter_zero (iter_zero),
    .last_iter (last_iter)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = INIT_D;
      INIT_D:  state_next = INIT_N;
      INIT_N:  state_next = iter_zero ? DONE : REF_D;
      REF_D:   state_next = REF_N;
      REF_N:   state_next = last_iter ? DONE : REF_D;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef GS_CTRL_ABORT_EN
    // DONE is excluded so a finished result is always delivered.
    if (abort && (state_reg != IDLE) && (state_reg != DONE)) begin
      state_next = IDLE;
    end
`endif
  end

  // Moore decode: outputs depend on state_reg only.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    load_regD  = 1'b0;
    load_regN  = 1'b0;
    sel_ND_mux = SEL_IA_D;
    sel_K_mux  = 1'b0;
    case (state_reg)
      INIT_D: begin
        busy       = 1'b1;
        load_regD  = 1'b1;
        sel_ND_mux = SEL_IA_D;
        sel_K_mux  = 1'b1;
      end
      INIT_N: begin
        busy       = 1'b1;
        load_regN  = 1'b1;
        sel_ND_mux = SEL_IA_N;
        sel_K_mux  = 1'b1;
      end
      REF_D: begin
        busy       = 1'b1;
        load_regD  = 1'b1;
        sel_ND_mux = SEL_K_D;
      end
      REF_N: begin
        busy       = 1'b1;
        load_regN  = 1'b1;
        sel_ND_mux = SEL_K_N;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed bench for goldschmidt_ctrl with a real-valued datapath model for co-simulation.
// The abort scenario is compiled in only when GS_CTRL_ABORT_EN is defined.
module tb_goldschmidt_ctrl;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_INIT_D = 7'b1010001;
  localparam logic [6:0] O_INIT_N = 7'b1001011;
  localparam logic [6:0] O_REF_D  = 7'b1010100;
  localparam logic [6:0] O_REF_N  = 7'b1001110;
  localparam logic [6:0] O_DONE   = 7'b1100000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_iter;
  logic       busy, done, load_regN, load_regD, sel_K_mux;
  logic [1:0] sel_ND_mux;
  logic [6:0] outs;
`ifdef GS_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int  n_total = 0;
  int  n_bad   = 0;
  int  done_cnt = 0;

  real ia = 0.75, n_in = 1.5, d_in = 1.25;
  real d_r = 0.0, n_r = 0.0, k_r = 0.0;

  goldschmidt_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_iter   (num_iter),
`ifdef GS_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .load_regN  (load_regN),
    .load_regD  (load_regD),
    .sel_ND_mux (sel_ND_mux),
    .sel_K_mux  (sel_K_mux)
  );

  always #5 clk = ~clk;

  assign outs = {busy, done, load_regD, load_regN, sel_ND_mux, sel_K_mux};

  always @(negedge clk) if (done) done_cnt++;

  // Datapath model: K is refreshed from the newest D each time N is loaded.
  always @(posedge clk) begin
    if (load_regD) d_r <= (sel_K_mux ? ia : k_r) * (sel_ND_mux[1] ? d_r : d_in);
    if (load_regN) begin
      n_r <= (sel_K_mux ? ia : k_r) * (sel_ND_mux[1] ? n_r : n_in);
      k_r <= 2.0 - d_r;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_out(input int c, input int iter);
    if (c == 1) return O_INIT_D;
    if (c == 2) return O_INIT_N;
    if (c >= 3 && c <= 2*iter + 2) return (c % 2 == 1) ? O_REF_D : O_REF_N;
    if (c == 2*iter + 3) return O_DONE;
    return O_IDLE;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int iter);
    num_iter = 4'(iter);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_check(input string tag, input int iter, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      check($sformatf("%s c%0d", tag, c), 32'(outs), 32'(exp_out(c, iter)));
      if (c < ncyc) tick();
    end
  endtask

  initial begin
    // 1: reset held with start asserted
    reset = 1'b0; start = 1'b1; num_iter = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", 32'(outs), 32'(O_IDLE));
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_idle%0d", i), 32'(outs), 32'(O_IDLE));
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    $display("scenario reset: total=%0d bad=%0d", n_total, n_bad);

    // 2: num_iter=4, plus datapath co-simulation
    done_cnt = 0;
    launch(4);
    run_check("iter4", 4, 12);
    check("iter4_done_cnt", 32'(done_cnt), 32'd1);
    check("iter4_quot_x1000", 32'($rtoi(n_r * 1000.0 + 0.5)), 32'd1200);
    $display("scenario iter4: total=%0d bad=%0d n=%f", n_total, n_bad, n_r);

    // 3: num_iter=0
    done_cnt = 0;
    launch(0);
    run_check("iter0", 0, 5);
    check("iter0_done_cnt", 32'(done_cnt), 32'd1);
    $display("scenario iter0: total=%0d bad=%0d", n_total, n_bad);

    // 4: start pulses while busy (mid-run and in DONE) are ignored
    done_cnt = 0;
    launch(2);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("busy_start c%0d", c), 32'(outs), 32'(exp_out(c, 2)));
      start = (c == 3 || c == 7);
      tick();
    end
    start = 1'b0;
    check("busy_start_done_cnt", 32'(done_cnt), 32'd1);
    $display("scenario start_while_busy: total=%0d bad=%0d", n_total, n_bad);

    // 5: reset mid-run, then a fresh num_iter=1 run
    done_cnt = 0;
    launch(4);
    for (int c = 1; c <= 4; c++) tick();
    check("midrst_pre", 32'(outs), 32'(O_REF_D));
    #2 reset = 1'b0;
    #1 check("midrst_async", 32'(outs), 32'(O_IDLE));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("midrst_idle", 32'(outs), 32'(O_IDLE));
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    launch(1);
    run_check("iter1", 1, 6);
    check("iter1_done_cnt", 32'(done_cnt), 32'd1);
    $display("scenario mid_reset: total=%0d bad=%0d", n_total, n_bad);

`ifdef GS_CTRL_ABORT_EN
    // 6: abort during refinement
    done_cnt = 0;
    launch(3);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("abort c%0d", c), 32'(outs), 32'(exp_out(c, 3)));
      if (c == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("abort_idle", 32'(outs), 32'(O_IDLE));
    for (int i = 0; i < 8; i++) tick();
    check("abort_still_idle", 32'(outs), 32'(O_IDLE));
    check("abort_no_done", 32'(done_cnt), 32'd0);
    $display("scenario abort: total=%0d bad=%0d", n_total, n_bad);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
